// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the I/D memory bus arbiter.
// Feature macro used by the arbiter: MEM_ARB_TIMEOUT_EN (slave-ack watchdog).
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DBUS = 2'd1,
    ST_IBUS = 2'd2
  } arb_state_e;

  localparam logic [3:0] SEL_WORD = 4'hF;

  // Counter width able to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for the arbiter: restarts on grant, counts bus cycles, flags expiry.
// Instantiated by mem_bus_arbiter only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_wdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = cnt_w(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = i_run & (r_cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory slave between the fetch (I) and data (D) masters.
// Optional slave-ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_req_o,
  output logic              err_o
);

  localparam int SC_W = cnt_w(STARVE_MAX);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  arb_state_e        r_state;
  logic [SC_W-1:0]   r_starve_cnt;
  logic              r_mem_ce;
  logic              r_mem_we;
  logic [3:0]        r_mem_sel;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_i_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_busy;
  logic w_abort;
  logic w_done;
  logic w_pick_d;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_done   = w_busy & (mem_ack_i | w_abort);
  // D keeps priority until it has won STARVE_MAX grants while I was waiting.
  assign w_pick_d = d_req_i & (~i_req_i | (r_starve_cnt < SC_MAX));

`ifdef MEM_ARB_TIMEOUT_EN
  logic w_grant;
  logic w_expire;
  logic r_err;

  assign w_grant = ~w_busy & (d_req_i | i_req_i);

  mem_arb_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_grant),
    .i_run    (w_busy),
    .o_expire (w_expire)
  );

  // A slave ack arriving on the last allowed cycle still wins over the abort.
  assign w_abort = w_expire & ~mem_ack_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_abort;
  end

  assign err_o = r_err;
`else
  assign w_abort = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_mem_ce     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_sel    <= 4'h0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_i_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!i_req_i) r_starve_cnt <= '0;
          if (w_pick_d) begin
            r_state     <= ST_DBUS;
            r_mem_ce    <= 1'b1;
            r_mem_we    <= d_we_i;
            r_mem_sel   <= d_sel_i;
            r_mem_addr  <= d_addr_i;
            r_mem_wdata <= d_wdata_i;
            if (i_req_i && (r_starve_cnt < SC_MAX)) r_starve_cnt <= r_starve_cnt + SC_W'(1);
          end else if (i_req_i) begin
            r_state      <= ST_IBUS;
            r_mem_ce     <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_sel    <= SEL_WORD;
            r_mem_addr   <= i_addr_i;
            r_mem_wdata  <= '0;
            r_starve_cnt <= '0;
          end
        end
        ST_DBUS: begin
          if (w_done) begin
            r_state   <= ST_IDLE;
            r_mem_ce  <= 1'b0;
            r_d_ack   <= 1'b1;
            r_d_rdata <= (w_abort || r_mem_we) ? '0 : mem_rdata_i;
          end
        end
        ST_IBUS: begin
          if (w_done) begin
            r_state   <= ST_IDLE;
            r_mem_ce  <= 1'b0;
            r_i_ack   <= 1'b1;
            r_i_rdata <= w_abort ? '0 : mem_rdata_i;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_ce <= 1'b0;
        end
      endcase
    end
  end

  assign mem_ce_o    = r_mem_ce;
  assign mem_we_o    = r_mem_we;
  assign mem_sel_o   = r_mem_sel;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign i_ack_o     = r_i_ack;
  assign d_ack_o     = r_d_ack;
  assign i_rdata_o   = r_i_rdata;
  assign d_rdata_o   = r_d_rdata;
  assign stall_req_o = (i_req_i & ~r_i_ack) | (d_req_i & ~r_d_ack);

endmodule
